// File: rtl/weight_loader.sv
// weight_loader: accepts a filter's 16-bit weights from an AXI4-Stream slave,
// two elements per 32-bit beat, and pushes one beat per fifo_en pulse into the
// weight buffer. The buffer has no full flag and drains one element per cycle,
// so an element-credit counter mirrors its occupancy and throttles tready.
module weight_loader #(
    parameter int data_width = 16,
    parameter int axi_width  = 32,
    parameter int buf_elems  = 26,
    parameter int max_dim    = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4:0]           weight_dim,
    input  logic [axi_width-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic                 fifo_en,
    output logic [axi_width-1:0] data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [6:0] TREADY_LIMIT = 7'(buf_elems - 2);
    localparam logic [4:0] MAX_DIM      = 5'(max_dim);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [6:0]           words_left;
    logic                 odd;
    logic [5:0]           credit;
    logic                 vld_p1;
    logic [axi_width-1:0] beat_p1;
    logic                 done_q;
    logic                 err_q;

    logic                 dim_legal;
    logic                 start_ok;
    logic                 start_bad;
    logic                 accept;
    logic                 final_beat;
    logic                 early_last;
    logic                 drained;

    // Number of beats for an N x N filter: ceil(N*N/2).
    function automatic logic [6:0] words_for_dim(input logic [4:0] n);
        logic [9:0] nn;
        nn = {5'd0, n} * {5'd0, n};
        return 7'((nn + 10'd1) >> 1);
    endfunction

    // Element credit update: a write adds two elements, the buffer drains one
    // per cycle whenever it holds anything (including the word just written).
    function automatic logic [5:0] credit_step(input logic [5:0] c, input logic wr);
        logic [5:0] inc;
        logic [5:0] dec;
        inc = wr ? 6'd2 : 6'd0;
        dec = ((c != 6'd0) || wr) ? 6'd1 : 6'd0;
        return c + inc - dec;
    endfunction

    // Final beat of an odd-sized filter carries only one real element.
    function automatic logic [axi_width-1:0] mask_beat(input logic [axi_width-1:0] d,
                                                       input logic               pad);
        return pad ? {{data_width{1'b0}}, d[data_width-1:0]} : d;
    endfunction

    assign dim_legal  = (weight_dim != 5'd0) && (weight_dim <= MAX_DIM);
    assign start_ok   = start && (state_q == IDLE) && dim_legal;
    assign start_bad  = start && (state_q == IDLE) && !dim_legal;
    assign accept     = s_axis_tvalid && s_axis_tready;
    assign final_beat = accept && (words_left == 7'd1);
    assign early_last = accept && s_axis_tlast && (words_left > 7'd1);
    assign drained    = (credit == 6'd0) && !vld_p1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (final_beat || early_last) state_d = DRAIN;
            DRAIN:   if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registers only; tready never looks at tvalid.
    always_comb begin
        s_axis_tready = (state_q == LOAD) &&
                        (({1'b0, credit} + (vld_p1 ? 7'd2 : 7'd0)) <= TREADY_LIMIT);
        busy          = (state_q != IDLE);
    end

    // Beat counter, parity and credit mirror of the buffer occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_left <= 7'd0;
            odd        <= 1'b0;
            credit     <= 6'd0;
        end else begin
            credit <= credit_step(credit, vld_p1);
            if (start_ok) begin
                words_left <= words_for_dim(weight_dim);
                odd        <= weight_dim[0];
            end else if (accept) begin
                words_left <= words_left - 7'd1;
            end
        end
    end

    // ---- stage p1: accepted beat presented to the weight buffer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            beat_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                beat_p1 <= mask_beat(s_axis_tdata, final_beat && odd);
            end
        end
    end

    // Completion pulse and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state_q == DRAIN) && drained;
            if (start_ok) begin
                err_q <= 1'b0;
            end else if (start_bad || (final_beat && !s_axis_tlast) || early_last) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fifo_en  = vld_p1;
    assign data_out = beat_p1;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// Testbench for weight_loader: randomized beats, scoreboard of expected
// buffer writes, occupancy model of the weight buffer, and protocol scenarios.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  weight_dim;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        fifo_en;
    logic [31:0] data_out;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    int fen_cnt, done_cnt, tready_low, occ, max_occ, occ_at_done;
    int cyc = 0;
    int done_cyc, t0;
    bit in_load = 0;

    weight_loader dut (
        .clk(clk), .rst(rst), .start(start), .weight_dim(weight_dim),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .fifo_en(fifo_en), .data_out(data_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every buffer write and models the buffer.
    always @(negedge clk) begin
        if (fifo_en === 1'b1) begin
            fen_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h required=none", data_out);
            end else begin
                check("beat_data", data_out, exp_q.pop_front());
            end
        end
        if (rst) begin
            occ = 0;
        end else begin
            if (fifo_en === 1'b1) occ = occ + 2;
            if (occ > max_occ) max_occ = occ;
            if (occ > 0) occ = occ - 1;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc    = cyc;
                occ_at_done = occ;
            end
            if (in_load && s_axis_tready !== 1'b1) tready_low++;
        end
    end

    task automatic clear_counts();
        fen_cnt = 0; done_cnt = 0; tready_low = 0; max_occ = 0; occ_at_done = -1;
    endtask

    task automatic start_pulse(input int n);
        start = 1'b1;
        weight_dim = 5'(n);
        @(posedge clk); #1;
        start = 1'b0;
        weight_dim = 5'($urandom);
    endtask

    // Start a load of dimension n and deliver nbeats beats; the last one
    // carries tlast when last_end is set. gap_pct is the idle-cycle percentage.
    task automatic load(input int n, input int nbeats, input bit last_end, input int gap_pct);
        int words, i, budget;
        bit odd, acc;
        logic [31:0] cur, e;
        words = (n * n + 1) / 2;
        odd = (n * n) % 2;
        t0 = cyc;
        start_pulse(n);
        in_load = 1;
        i = 0;
        budget = 0;
        cur = $urandom;
        while (i < nbeats && budget < 3000) begin
            s_axis_tvalid = ($urandom_range(99) >= gap_pct);
            s_axis_tdata  = cur;
            s_axis_tlast  = last_end && (i == nbeats - 1);
            @(negedge clk);
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge clk); #1;
            if (acc) begin
                e = cur;
                if (i == words - 1 && odd) e[31:16] = 16'h0;
                exp_q.push_back(e);
                i++;
                cur = $urandom;
            end
            budget++;
        end
        in_load = 0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("load_beats_accepted", i, nbeats);
    endtask

    // Offer junk beats that must not be taken, wait for done, then audit.
    task automatic finish_load(input int nbeats, input bit exp_err);
        int n;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = $urandom;
        s_axis_tlast  = 1'b1;
        n = 0;
        while (done_cnt == 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("done_seen", done_cnt > 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("write_count", fen_cnt, nbeats);
        check("scoreboard_empty", exp_q.size(), 0);
        check("buffer_empty_at_done", occ_at_done, 0);
        check("err_flag", err, exp_err);
        check("idle_after_done", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, s_axis_tready, 0);
        check({tag, "_fifo_en"}, fifo_en, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; weight_dim = 5'd0;
        s_axis_tdata = 32'h0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        occ = 0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // N=3, back-to-back, tlast on beat 5, upper half of beat 5 zeroed
        clear_counts();
        load(3, 5, 1, 0);
        finish_load(5, 0);

        // N=15, 113 beats, credit throttling
        clear_counts();
        load(15, 113, 1, 0);
        finish_load(113, 0);
        check("occupancy_bound", max_occ <= 26, 1);
        check("tready_throttled", tready_low > 0, 1);
        check("n15_duration", (done_cyc - t0 >= 220) && (done_cyc - t0 <= 250), 1);

        // N=4 with random idle cycles
        clear_counts();
        load(4, 8, 1, 30);
        finish_load(8, 0);

        // Illegal dimensions
        clear_counts();
        start_pulse(0);
        @(negedge clk);
        check("dim0_err", err, 1);
        check("dim0_busy", busy, 0);
        @(posedge clk); #1;
        start_pulse(16);
        @(negedge clk);
        check("dim16_err", err, 1);
        check("dim16_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_no_done", done_cnt, 0);
        // Legal N=1 clears err
        load(1, 1, 1, 0);
        finish_load(1, 0);

        // N=5, early tlast on beat 7 of 13
        clear_counts();
        load(5, 7, 1, 0);
        @(negedge clk);
        check("early_last_tready", s_axis_tready, 0);
        check("early_last_err", err, 1);
        @(posedge clk); #1;
        finish_load(7, 1);

        // Reset mid-load after beat 4 of N=6
        clear_counts();
        load(6, 4, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (6) @(negedge clk);
        check("midreset_writes", fen_cnt, 4);
        check("midreset_no_done", done_cnt, 0);
        check("midreset_scoreboard", exp_q.size(), 0);
        @(posedge clk); #1;

        // Fresh N=2 load after reset
        clear_counts();
        load(2, 2, 1, 0);
        finish_load(2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
